// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared constants for the character display RAM: geometry (40x30 cells), bus
// widths, and the clear-screen sequencer state encoding. The text renderer
// imports the same package, so cell addressing (hp + vp*COLS) stays consistent.
// -----------------------------------------------------------------------------
package text_pkg;

  localparam int COLS  = 40;           // characters per row
  localparam int ROWS  = 30;           // character rows
  localparam int DEPTH = COLS * ROWS;  // valid cell count (1200)
  localparam int AW    = 12;           // cell address width
  localparam int DW    = 8;            // character code width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/text_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// text_mem_arbiter_if
// Bundles every requester-side and RAM-side signal of the display RAM arbiter.
//   video : vid_req, vid_addr -> vid_data (1-cycle fetch)
//   cpu   : cpu_valid/cpu_ready handshake, cpu_we/addr/wdata,
//           cpu_rvalid/cpu_rdata read return, cpu_oor sticky flag
//   clear : clr_start, clr_char -> clr_busy
//   ram   : mem_en/we/addr/wdata out, mem_rdata in (registered read)
// The slave modport is the arbiter; the master modport is its environment
// (requesters plus the RAM macro).
// -----------------------------------------------------------------------------
interface text_mem_arbiter_if;
  import text_pkg::*;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;

  logic          cpu_valid;
  logic          cpu_ready;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_oor;

  logic          clr_start;
  logic [DW-1:0] clr_char;
  logic          clr_busy;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata,
           clr_start, clr_char, mem_rdata,
    output vid_data, cpu_ready, cpu_rvalid, cpu_rdata, cpu_oor, clr_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata,
           clr_start, clr_char, mem_rdata,
    input  vid_data, cpu_ready, cpu_rvalid, cpu_rdata, cpu_oor, clr_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/text_clear_seq.sv
// -----------------------------------------------------------------------------
// text_clear_seq
// Clear-screen engine: on i_start (while idle) latches the fill code and walks
// addresses 0..DEPTH-1, issuing one write request per cycle. A write completes
// only in cycles where i_grant is high, so stolen cycles simply stretch the
// sweep without skipping or repeating a cell.
//   clk, clr       : clock, synchronous active-high reset
//   i_start        : start request (ignored while clearing)
//   i_fill         : fill code, sampled with i_start
//   i_grant        : RAM slot available this cycle
//   o_req          : write request pending
//   o_addr, o_data : write address / fill code
//   o_busy         : clear in progress
// -----------------------------------------------------------------------------
module text_clear_seq
  import text_pkg::*;
#(
  parameter int DEPTH = text_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_start,
  input  logic [DW-1:0] i_fill,
  input  logic          i_grant,
  output logic          o_req,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_busy
);

  clr_state_t    r_state;
  clr_state_t    w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_fill;
  logic          w_last;

  assign w_last = (r_cnt == AW'(DEPTH - 1));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its inputs from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default is assigned before the case so every path drives
  // w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start)           w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (i_grant && w_last) w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter only advances on a granted write; it is parked at 0 when idle so
  // a reset mid-sweep or a fresh start always begins at cell 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt  <= '0;
      r_fill <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_cnt  <= '0;
        r_fill <= i_fill;
      end
    end else if (i_grant) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_req  = (r_state == ST_CLEAR);
  assign o_busy = (r_state == ST_CLEAR);
  assign o_addr = r_cnt;
  assign o_data = r_fill;

endmodule

// File: rtl/text_mem_arbiter.sv
// -----------------------------------------------------------------------------
// text_mem_arbiter
// Shares the single-port character RAM between the text renderer (highest
// priority, guaranteed 1-cycle fetch), the clear-screen engine, and the CPU.
// At most one RAM access is issued per cycle; mem_* are combinational from the
// winner and registered inside the RAM macro.
//   clk, clr : clock, synchronous active-high reset
//   bus      : slave side of text_mem_arbiter_if (video, cpu, clear, ram)
// -----------------------------------------------------------------------------
module text_mem_arbiter
  import text_pkg::*;
#(
  parameter int COLS  = text_pkg::COLS,
  parameter int ROWS  = text_pkg::ROWS,
  parameter int DEPTH = COLS * ROWS
) (
  input logic              clk,
  input logic              clr,
  text_mem_arbiter_if.slave bus
);

  logic          w_clr_grant;
  logic          w_clr_req;
  logic [AW-1:0] w_clr_addr;
  logic [DW-1:0] w_clr_data;
  logic          w_clr_busy;
  logic          w_cpu_ready;
  logic          w_cpu_accept;
  logic          w_cpu_in_range;
  logic          r_rvalid;
  logic          r_rd_oor;
  logic          r_oor;

  // Video owns any cycle it requests; the clear engine gets the rest.
  assign w_clr_grant = !bus.vid_req;

  text_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk     (clk),
    .clr     (clr),
    .i_start (bus.clr_start),
    .i_fill  (bus.clr_char),
    .i_grant (w_clr_grant),
    .o_req   (w_clr_req),
    .o_addr  (w_clr_addr),
    .o_data  (w_clr_data),
    .o_busy  (w_clr_busy)
  );

  // CPU is locked out during a clear and in the start cycle itself, so a
  // clear never shares its first slot with a CPU access.
  assign w_cpu_ready    = !clr && !w_clr_busy && !bus.vid_req && !bus.clr_start;
  assign w_cpu_accept   = bus.cpu_valid && w_cpu_ready;
  assign w_cpu_in_range = (bus.cpu_addr < AW'(DEPTH));

  // Priority mux; RAM controls are held quiet while in reset.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!clr) begin
      if (bus.vid_req) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.vid_addr;
      end else if (w_clr_req) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_clr_addr;
        bus.mem_wdata = w_clr_data;
      end else if (w_cpu_accept && w_cpu_in_range) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
      end
    end
  end

  // Read return tracking. r_rd_oor masks the RAM data for an out-of-range
  // read, which never touched the RAM.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rvalid <= 1'b0;
      r_rd_oor <= 1'b0;
      r_oor    <= 1'b0;
    end else begin
      r_rvalid <= w_cpu_accept && !bus.cpu_we;
      r_rd_oor <= w_cpu_accept && !bus.cpu_we && !w_cpu_in_range;
      if (w_cpu_accept && !w_cpu_in_range) r_oor <= 1'b1;
    end
  end

  assign bus.vid_data   = bus.mem_rdata;
  assign bus.cpu_ready  = w_cpu_ready;
  assign bus.cpu_rvalid = r_rvalid;
  assign bus.cpu_rdata  = r_rd_oor ? '0 : bus.mem_rdata;
  assign bus.cpu_oor    = r_oor;
  assign bus.clr_busy   = w_clr_busy;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_text_mem_arbiter
// Directed bench for text_mem_arbiter with a behavioural single-port RAM
// (registered read) and a write log of every RAM write.
// -----------------------------------------------------------------------------
module tb_text_mem_arbiter;
  import text_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  text_mem_arbiter_if bus ();

  text_mem_arbiter u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // Behavioural RAM plus a bulk preload port (mode 1: pattern, 2: constant).
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] r_rd;
  int            pre_mode = 0;
  logic [DW-1:0] pre_val  = '0;
  logic [AW-1:0] wlog [$];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (pre_mode != 0) begin
      for (int i = 0; i < 4096; i++)
        ram[i] <= (pre_mode == 1) ? pat(AW'(i)) : pre_val;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            r_rd <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = r_rd;

  always @(posedge clk)
    if (bus.mem_en && bus.mem_we) wlog.push_back(bus.mem_addr);

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int mode, input logic [DW-1:0] val);
    pre_mode = mode;
    pre_val  = val;
    tick;
    pre_mode = 0;
  endtask

  // Writes in the log after index base that are not exactly 0,1,2,... in order.
  function automatic int order_errs(input int base);
    int errs = 0;
    for (int k = 0; k < wlog.size() - base; k++)
      if (wlog[base + k] != AW'(k)) errs++;
    return errs;
  endfunction

  function automatic int ram_errs(input logic [DW-1:0] v);
    int errs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== v) errs++;
    return errs;
  endfunction

  // Wait for clr_busy to drop; returns cycles spent busy, -1 on timeout.
  task automatic wait_clear(output int cyc);
    cyc = -1;
    for (int i = 0; i < 4000; i++) begin
      if (!bus.clr_busy) begin cyc = i; break; end
      tick;
    end
  endtask

  int            base, busy_cyc, stolen, cyc;
  logic          seen, done;
  logic [AW-1:0] va;
  logic [DW-1:0] vexp;

  initial begin
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.cpu_valid = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 0; bus.clr_char = '0;

    // Reset state
    tick; tick;
    check("rst_busy",   bus.clr_busy,   0);
    check("rst_rvalid", bus.cpu_rvalid, 0);
    check("rst_oor",    bus.cpu_oor,    0);
    check("rst_mem_en", bus.mem_en,     0);
    check("rst_mem_we", bus.mem_we,     0);
    check("rst_addr",   bus.mem_addr,   0);
    check("rst_wdata",  bus.mem_wdata,  0);
    clr = 0;
    tick;

    // Video fetch with a competing CPU request
    preload(2, 8'h41);
    bus.vid_req = 1; bus.vid_addr = 12'd41;
    bus.cpu_valid = 1; bus.cpu_we = 0; bus.cpu_addr = 12'd3;
    #1;
    check("vid_cpu_ready", bus.cpu_ready, 0);
    check("vid_mem_en",    bus.mem_en,    1);
    check("vid_mem_we",    bus.mem_we,    0);
    check("vid_mem_addr",  bus.mem_addr,  41);
    tick;
    bus.vid_req = 0; bus.cpu_valid = 0;
    check("vid_data",      bus.vid_data,   8'h41);
    check("vid_no_rvalid", bus.cpu_rvalid, 0);

    // CPU write then read of the last valid cell
    bus.cpu_valid = 1; bus.cpu_we = 1; bus.cpu_addr = 12'd1199; bus.cpu_wdata = 8'h5A;
    #1;
    check("wr_ready",   bus.cpu_ready, 1);
    check("wr_mem_we",  bus.mem_we,    1);
    check("wr_addr",    bus.mem_addr,  1199);
    tick;
    bus.cpu_valid = 0;
    check("wr_ram",     ram[1199],     8'h5A);
    check("wr_no_rval", bus.cpu_rvalid, 0);
    bus.cpu_valid = 1; bus.cpu_we = 0;
    tick;
    bus.cpu_valid = 0;
    check("rd_rvalid", bus.cpu_rvalid, 1);
    check("rd_data",   bus.cpu_rdata,  8'h5A);
    tick;
    check("rd_rvalid_pulse", bus.cpu_rvalid, 0);

    // Out-of-range write and read
    bus.cpu_valid = 1; bus.cpu_we = 1; bus.cpu_addr = 12'd1200; bus.cpu_wdata = 8'h99;
    #1;
    check("oor_wr_ready",  bus.cpu_ready, 1);
    check("oor_wr_mem_en", bus.mem_en,    0);
    tick;
    check("oor_set", bus.cpu_oor, 1);
    bus.cpu_we = 0; bus.cpu_addr = 12'd4095;
    #1;
    check("oor_rd_mem_en", bus.mem_en, 0);
    tick;
    bus.cpu_valid = 0;
    check("oor_rd_rvalid", bus.cpu_rvalid, 1);
    check("oor_rd_data",   bus.cpu_rdata,  0);
    tick; tick;
    check("oor_sticky", bus.cpu_oor, 1);

    // Clear without video; fill code must be the one sampled at start
    preload(2, 8'hFF);
    base = wlog.size();
    bus.clr_start = 1; bus.clr_char = 8'h20;
    #1;
    check("clr_start_ready", bus.cpu_ready, 0);
    check("clr_start_busy",  bus.clr_busy,  0);
    tick;
    bus.clr_start = 0; bus.clr_char = 8'hEE;
    wait_clear(busy_cyc);
    check("clr_busy_cycles", busy_cyc, 1200);
    check("clr_writes", wlog.size() - base, 1200);
    check("clr_order",  order_errs(base), 0);
    check("clr_cells",  ram_errs(8'h20), 0);
    check("clr_beyond", ram[1200], 8'hFF);
    bus.cpu_valid = 1; bus.cpu_we = 0; bus.cpu_addr = 12'd600;
    tick;
    bus.cpu_valid = 0;
    check("clr_readback", bus.cpu_rdata, 8'h20);

    // Clear under video every 8th cycle; first video coincides with start
    preload(1, 8'h00);
    base = wlog.size(); stolen = 0; busy_cyc = 0; seen = 0; done = 0;
    bus.clr_char = 8'h2E; bus.clr_start = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) bus.clr_start = 0;
      if (seen && !bus.clr_busy) begin done = 1; break; end
      if (bus.clr_busy) begin seen = 1; busy_cyc++; end
      bus.vid_req = (c % 8 == 0);
      if (bus.vid_req) begin
        va = AW'((c * 37) % 1200);
        bus.vid_addr = va;
        vexp = (int'(va) < wlog.size() - base) ? 8'h2E : pat(va);
        if (bus.clr_busy) stolen++;
      end
      tick;
      if (c == 0) check("cv_busy_after_collision", bus.clr_busy, 1);
      if (bus.vid_req) check("cv_vid_data", bus.vid_data, vexp);
    end
    bus.vid_req = 0;
    check("cv_done",     done, 1);
    check("cv_duration", busy_cyc, 1200 + stolen);
    check("cv_writes",   wlog.size() - base, 1200);
    check("cv_order",    order_errs(base), 0);
    check("cv_cells",    ram_errs(8'h2E), 0);

    // Reset in the middle of a clear
    base = wlog.size();
    bus.clr_char = 8'h11; bus.clr_start = 1;
    tick;
    bus.clr_start = 0;
    for (int i = 0; i < 2000; i++) begin
      if (wlog.size() - base >= 600) break;
      tick;
    end
    check("mid_count", wlog.size() - base, 600);
    clr = 1;
    tick;
    clr = 0;
    check("mid_busy", bus.clr_busy, 0);
    check("mid_oor_cleared", bus.cpu_oor, 0);
    check("mid_cell_599", ram[599], 8'h11);
    check("mid_cell_600", ram[600], 8'h2E);
    bus.cpu_valid = 1; bus.cpu_we = 1; bus.cpu_addr = 12'd5; bus.cpu_wdata = 8'h77;
    #1;
    check("mid_cpu_ready", bus.cpu_ready, 1);
    tick;
    bus.cpu_valid = 0;
    check("mid_cpu_write", ram[5], 8'h77);
    base = wlog.size();
    bus.clr_char = 8'h33; bus.clr_start = 1;
    tick;
    bus.clr_start = 0;
    wait_clear(cyc);
    check("mid_restart_cycles", cyc, 1200);
    check("mid_restart_first", (wlog.size() > base) ? 32'(wlog[base]) : 32'hFFFF, 0);
    check("mid_restart_order", order_errs(base), 0);
    check("mid_restart_cells", ram_errs(8'h33), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
